// File: rtl/fdiv_multi.sv
// rtl/fdiv_multi.sv - multi-channel programmable clock divider with staged DIV/HIGH updates
// Optional FDIV_PHASE_EN adds phase_in: a disabled channel parks its counter at a programmable phase.
module fdiv_multi #(
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 16,
  parameter int DEF_DIV  = 2
) (
  input  logic                      clk_in,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*CNT_W-1:0] div_in,
  input  logic [CHANNELS*CNT_W-1:0] high_in,
`ifdef FDIV_PHASE_EN
  input  logic [CHANNELS*CNT_W-1:0] phase_in,
`endif
  output logic [CHANNELS-1:0]       clk_out,
  output logic [CHANNELS-1:0]       tick,
  output logic [CHANNELS-1:0]       pend
);

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);
  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_DIV / 2);

  logic [CNT_W-1:0]    cnt       [CHANNELS];
  logic [CNT_W-1:0]    act_div   [CHANNELS];
  logic [CNT_W-1:0]    act_high  [CHANNELS];
  logic [CNT_W-1:0]    pend_div  [CHANNELS];
  logic [CNT_W-1:0]    pend_high [CHANNELS];
  logic [CNT_W-1:0]    last_cnt  [CHANNELS];
  logic [CNT_W-1:0]    idle_cnt  [CHANNELS];
  logic [CHANNELS-1:0] wrap;

  // DIV of 0 or 1 behaves as 2, so last_cnt never underflows.
  always_comb begin
    for (int k = 0; k < CHANNELS; k++) begin
      last_cnt[k] = ((act_div[k] < TWO) ? TWO : act_div[k]) - ONE;
      wrap[k]     = en[k] && (cnt[k] >= last_cnt[k]);
`ifdef FDIV_PHASE_EN
      idle_cnt[k] = (phase_in[k*CNT_W +: CNT_W] > last_cnt[k]) ? last_cnt[k]
                                                               : phase_in[k*CNT_W +: CNT_W];
`else
      idle_cnt[k] = '0;
`endif
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        cnt[k]       <= '0;
        act_div[k]   <= RST_DIV;
        act_high[k]  <= RST_HIGH;
        pend_div[k]  <= '0;
        pend_high[k] <= '0;
      end
      clk_out <= '0;
      tick    <= '0;
      pend    <= '0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (en[k]) begin
          clk_out[k] <= (cnt[k] < act_high[k]);
          tick[k]    <= (cnt[k] == '0);
          cnt[k]     <= wrap[k] ? '0 : cnt[k] + ONE;
        end else begin
          clk_out[k] <= 1'b0;
          tick[k]    <= 1'b0;
          cnt[k]     <= idle_cnt[k];
        end

        // Active values only change while stopped or at a period boundary; a fresh load beats staged values.
        if (!en[k] || wrap[k]) begin
          if (load[k]) begin
            act_div[k]  <= div_in[k*CNT_W +: CNT_W];
            act_high[k] <= high_in[k*CNT_W +: CNT_W];
          end else if (pend[k]) begin
            act_div[k]  <= pend_div[k];
            act_high[k] <= pend_high[k];
          end
          pend[k] <= 1'b0;
        end else if (load[k]) begin
          pend_div[k]  <= div_in[k*CNT_W +: CNT_W];
          pend_high[k] <= high_in[k*CNT_W +: CNT_W];
          pend[k]      <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fdiv_multi.sv
// tb/tb_fdiv_multi.sv - directed-vector bench for fdiv_multi (default build, channel 0 exercised)
module tb_fdiv_multi;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [3:0]  en;
  logic [3:0]  load;
  logic [63:0] div_in;
  logic [63:0] high_in;
  logic [3:0]  clk_out;
  logic [3:0]  tick;
  logic [3:0]  pend;

  int n_vec = 0;
  int n_err = 0;

  fdiv_multi #(.CHANNELS(4), .CNT_W(16), .DEF_DIV(2)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .high_in (high_in),
    .clk_out (clk_out),
    .tick    (tick),
    .pend    (pend)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic stage_ch0(input logic [15:0] d, input logic [15:0] h);
    div_in[15:0]  = d;
    high_in[15:0] = h;
    load          = 4'b0001;
  endtask

  // Bit i of ce/te is the expected ch0 clk_out/tick after the i-th edge.
  task automatic run(input string tag, input int n, input logic [31:0] ce, input logic [31:0] te);
    for (int i = 0; i < n; i++) begin
      step();
      chk($sformatf("%s.clk[%0d]", tag, i), 32'(clk_out[0]), 32'(ce[i]));
      chk($sformatf("%s.tick[%0d]", tag, i), 32'(tick[0]), 32'(te[i]));
      chk($sformatf("%s.idle[%0d]", tag, i), 32'({clk_out[3:1], tick[3:1]}), 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; en = 4'b0000; load = 4'b0000; div_in = '0; high_in = '0;
    step();
    step();
    chk("rst.clk", 32'(clk_out), 32'd0);
    chk("rst.tick", 32'(tick), 32'd0);
    chk("rst.pend", 32'(pend), 32'd0);
    reset = 1'b0;

    // 1: defaults DIV=2 HIGH=1
    en = 4'b0001;
    run("t1", 4, 32'h5, 32'h5);
    chk("t1.pend", 32'(pend), 32'd0);

    // 2: load while stopped, then run DIV=5 HIGH=2
    en = 4'b0000;
    stage_ch0(16'd5, 16'd2);
    step();
    chk("t2.pend_idle", 32'(pend), 32'd0);
    load = 4'b0000;
    en   = 4'b0001;
    run("t2", 10, 32'h063, 32'h021);

    // 3: DIV=4 HIGH=2 running, staged DIV=6 HIGH=3 mid-period
    en = 4'b0000;
    stage_ch0(16'd4, 16'd2);
    step();
    load = 4'b0000;
    en   = 4'b0001;
    run("t3a", 2, 32'h3, 32'h1);
    stage_ch0(16'd6, 16'd3);
    step();
    chk("t3.clk_c2", 32'(clk_out[0]), 32'd0);
    chk("t3.pend_set", 32'(pend), 32'd1);
    load = 4'b0000;
    step();
    chk("t3.clk_c3", 32'(clk_out[0]), 32'd0);
    chk("t3.pend_clr", 32'(pend), 32'd0);
    run("t3b", 6, 32'h07, 32'h01);

    // 4: load on the wrap edge bypasses staging
    run("t4a", 5, 32'h07, 32'h01);
    stage_ch0(16'd3, 16'd1);
    step();
    chk("t4.wrap_clk", 32'(clk_out[0]), 32'd0);
    chk("t4.wrap_pend", 32'(pend), 32'd0);
    load = 4'b0000;
    run("t4b", 6, 32'h09, 32'h09);
    run("t4c", 2, 32'h1, 32'h1);
    stage_ch0(16'd3, 16'd0);
    step();
    chk("t4.h0_pend", 32'(pend), 32'd0);
    load = 4'b0000;
    run("t4d", 6, 32'h00, 32'h09);
    run("t4e", 2, 32'h0, 32'h1);
    stage_ch0(16'd3, 16'd9);
    step();
    load = 4'b0000;
    run("t4f", 6, 32'h3F, 32'h09);

    // 5: DIV=1 acts as 2, then reset with staged values pending
    en = 4'b0000;
    stage_ch0(16'd1, 16'd1);
    step();
    load = 4'b0000;
    en   = 4'b0001;
    run("t5a", 4, 32'h5, 32'h5);
    stage_ch0(16'd7, 16'd3);
    step();
    chk("t5.pend_set", 32'(pend), 32'd1);
    load = 4'b0000;
    step();
    chk("t5.pend_wrap", 32'(pend), 32'd0);
    run("t5b", 2, 32'h3, 32'h1);
    stage_ch0(16'd4, 16'd1);
    step();
    chk("t5.pend_mid", 32'(pend), 32'd1);
    load  = 4'b0000;
    reset = 1'b1;
    step();
    chk("t5.rst_clk", 32'(clk_out), 32'd0);
    chk("t5.rst_tick", 32'(tick), 32'd0);
    chk("t5.rst_pend", 32'(pend), 32'd0);
    reset = 1'b0;
    run("t5c", 4, 32'h5, 32'h5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
